// File: rtl/cdb_pkg.sv
// Shared types and the wrapped round-robin scan for the CDB transmitter.
package cdb_pkg;

    localparam int TAG_W      = 6;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int RR_MAX_SRC = 16;
    localparam int RR_IDX_W   = 4;

    typedef struct packed {
        logic              redirect;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } cdb_entry_t;

    // Returns {found, index}: first set bit scanning ptr, ptr+1, ... modulo n_src.
    function automatic logic [RR_IDX_W:0] rr_pick(
        input logic [RR_MAX_SRC-1:0] valid_vec,
        input logic [RR_IDX_W-1:0]   ptr,
        input int unsigned           n_src
    );
        logic [RR_IDX_W:0] res;
        int unsigned       idx;
        res = {(RR_IDX_W+1){1'b0}};
        for (int unsigned i = 0; i < RR_MAX_SRC; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= n_src) begin
                idx = idx - n_src;
            end else begin
                idx = idx;
            end
            if (i < n_src && !res[RR_IDX_W] && valid_vec[idx[RR_IDX_W-1:0]]) begin
                res = {1'b1, idx[RR_IDX_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO; flush and reset both empty it without touching storage.
module cdb_src_fifo #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push_s, do_pop_s;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign o_empty   = (cnt_q == CW'(0));
    assign o_full    = (cnt_q == CW'(DEPTH));
    assign o_data    = mem_q[rd_ptr_q];
    assign do_push_s = i_push && !o_full;
    assign do_pop_s  = i_pop && !o_empty;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = do_push_s ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop_s ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; stale contents are harmless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: per-source FIFOs, round-robin grant, one registered broadcast per cycle.
// Optional macro CDB_REDIRECT_PRIORITY_EN lets redirect heads win arbitration.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic [N_SRC-1:0]            i_fu_valid,
    input  logic [N_SRC-1:0]            i_fu_redirect,
    input  logic [N_SRC*TAG_WIDTH-1:0]  i_fu_tag,
    input  logic [N_SRC*DATA_WIDTH-1:0] i_fu_data,
    input  logic [N_SRC*ADDR_WIDTH-1:0] i_fu_addr,
    output logic [N_SRC-1:0]            o_fu_ready,
    output logic                        o_cdb_en,
    output logic                        o_cdb_redirect,
    output logic [TAG_WIDTH-1:0]        o_cdb_tag,
    output logic [DATA_WIDTH-1:0]       o_cdb_data,
    output logic [ADDR_WIDTH-1:0]       o_cdb_addr
);
    localparam int EW    = 1 + TAG_WIDTH + DATA_WIDTH + ADDR_WIDTH;
    localparam int PTR_W = $clog2(N_SRC);

    logic [N_SRC-1:0]    empty_s, full_s, push_s, pop_s, cand_s, pick_vec_s;
    logic [EW-1:0]       head_s [N_SRC];
    logic [EW-1:0]       grant_entry_s;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d, grant_idx_s;
    logic [RR_IDX_W:0]   pick_s;
    logic                grant_s;

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_src
            cdb_src_fifo #(
                .WIDTH (EW),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_flush (i_flush),
                .i_push  (push_s[g]),
                .i_data  ({i_fu_redirect[g],
                           i_fu_tag[g*TAG_WIDTH +: TAG_WIDTH],
                           i_fu_data[g*DATA_WIDTH +: DATA_WIDTH],
                           i_fu_addr[g*ADDR_WIDTH +: ADDR_WIDTH]}),
                .i_pop   (pop_s[g]),
                .o_data  (head_s[g]),
                .o_empty (empty_s[g]),
                .o_full  (full_s[g])
            );
        end
    endgenerate

    // Ready comes straight from registered occupancy, so no input reaches it combinationally.
    assign o_fu_ready = ~full_s;
    assign push_s     = i_fu_valid & ~full_s;
    assign cand_s     = ~empty_s;

`ifdef CDB_REDIRECT_PRIORITY_EN
    logic [N_SRC-1:0] head_redir_s;
    logic [N_SRC-1:0] redir_cand_s;
    for (g = 0; g < N_SRC; g++) begin : g_redir
        assign head_redir_s[g] = head_s[g][EW-1];
    end
    assign redir_cand_s = cand_s & head_redir_s;
    assign pick_vec_s   = (|redir_cand_s) ? redir_cand_s : cand_s;
`else
    assign pick_vec_s = cand_s;
`endif

    assign pick_s        = rr_pick(RR_MAX_SRC'(pick_vec_s), RR_IDX_W'(rr_ptr_q), N_SRC);
    assign grant_s       = pick_s[RR_IDX_W];
    assign grant_idx_s   = PTR_W'(pick_s[RR_IDX_W-1:0]);
    assign grant_entry_s = head_s[grant_idx_s];

    // Pop the granted source and advance the pointer past it; a flush freezes both.
    always_comb begin
        pop_s = {N_SRC{1'b0}};
        if (grant_s && !i_flush) begin
            pop_s[grant_idx_s] = 1'b1;
            rr_ptr_d = (grant_idx_s == PTR_W'(N_SRC - 1)) ? {PTR_W{1'b0}} : grant_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Broadcast register; payload holds its last value on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= {PTR_W{1'b0}};
            o_cdb_en       <= 1'b0;
            o_cdb_redirect <= 1'b0;
            o_cdb_tag      <= {TAG_WIDTH{1'b0}};
            o_cdb_data     <= {DATA_WIDTH{1'b0}};
            o_cdb_addr     <= {ADDR_WIDTH{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (i_flush) begin
                o_cdb_en <= 1'b0;
            end else if (grant_s) begin
                o_cdb_en <= 1'b1;
                {o_cdb_redirect, o_cdb_tag, o_cdb_data, o_cdb_addr} <= grant_entry_s;
            end else begin
                o_cdb_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts every broadcast.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NS    = 4;
    localparam int DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst, i_flush;
    logic [NS-1:0]        i_fu_valid, i_fu_redirect;
    logic [NS*TAG_W-1:0]  i_fu_tag;
    logic [NS*DATA_W-1:0] i_fu_data;
    logic [NS*ADDR_W-1:0] i_fu_addr;
    logic [NS-1:0]        o_fu_ready;
    logic                 o_cdb_en, o_cdb_redirect;
    logic [TAG_W-1:0]     o_cdb_tag;
    logic [DATA_W-1:0]    o_cdb_data;
    logic [ADDR_W-1:0]    o_cdb_addr;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .N_SRC(NS), .DATA_WIDTH(DATA_W), .ADDR_WIDTH(ADDR_W), .TAG_WIDTH(TAG_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_fu_valid(i_fu_valid), .i_fu_redirect(i_fu_redirect), .i_fu_tag(i_fu_tag),
        .i_fu_data(i_fu_data), .i_fu_addr(i_fu_addr), .o_fu_ready(o_fu_ready),
        .o_cdb_en(o_cdb_en), .o_cdb_redirect(o_cdb_redirect), .o_cdb_tag(o_cdb_tag),
        .o_cdb_data(o_cdb_data), .o_cdb_addr(o_cdb_addr)
    );

    typedef struct packed {
        logic          en;
        logic [NS-1:0] ready;
        cdb_entry_t    e;
    } exp_t;

    exp_t             exp_q[$];
    logic [TAG_W-1:0] log_q[$];
    cdb_entry_t       m_mem [NS][DEPTH];
    int               m_cnt [NS];
    int               m_rr;
    logic             m_en;
    cdb_entry_t       m_last;
    cdb_entry_t       stim [NS][16];
    int               s_head [NS];
    int               s_tail [NS];
    int               n_cmp, n_err;
    bit               saw_ready1_low;

    task automatic check_eq(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic add_stim(input int s, input logic red, input logic [TAG_W-1:0] tag,
                            input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] addr);
        stim[s][s_tail[s]] = {red, tag, data, addr};
        s_tail[s]++;
    endtask

    task automatic drive_inputs();
        cdb_entry_t e;
        for (int s = 0; s < NS; s++) begin
            if (s_head[s] < s_tail[s]) begin
                e = stim[s][s_head[s]];
                i_fu_valid[s] = 1'b1;
            end else begin
                e = '0;
                i_fu_valid[s] = 1'b0;
            end
            i_fu_redirect[s]                = e.redirect;
            i_fu_tag[s*TAG_W +: TAG_W]      = e.tag;
            i_fu_data[s*DATA_W +: DATA_W]   = e.data;
            i_fu_addr[s*ADDR_W +: ADDR_W]   = e.addr;
        end
    endtask

    function automatic int pick_model(input bit redir_only);
        int s;
        for (int i = 0; i < NS; i++) begin
            s = (m_rr + i) % NS;
            if (m_cnt[s] > 0 && (!redir_only || m_mem[s][0].redirect)) return s;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int   pre [NS];
        int   g;
        exp_t x;
        for (int s = 0; s < NS; s++) pre[s] = m_cnt[s];
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                m_cnt[s] = 0; s_head[s] = 0; s_tail[s] = 0;
            end
            m_rr = 0; m_en = 1'b0; m_last = '0;
        end else if (i_flush) begin
            for (int s = 0; s < NS; s++) begin
                if (i_fu_valid[s] && pre[s] < DEPTH) s_head[s]++;
                m_cnt[s] = 0;
            end
            m_en = 1'b0;
        end else begin
            g = -1;
`ifdef CDB_REDIRECT_PRIORITY_EN
            g = pick_model(1'b1);
`endif
            if (g < 0) g = pick_model(1'b0);
            if (g >= 0) begin
                m_last = m_mem[g][0];
                for (int j = 0; j < DEPTH - 1; j++) m_mem[g][j] = m_mem[g][j+1];
                m_cnt[g]--;
                m_rr = (g + 1) % NS;
                m_en = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            for (int s = 0; s < NS; s++) begin
                if (i_fu_valid[s] && pre[s] < DEPTH) begin
                    m_mem[s][m_cnt[s]] = stim[s][s_head[s]];
                    m_cnt[s]++;
                    s_head[s]++;
                end
            end
        end
        x.en = m_en;
        x.e  = m_last;
        for (int s = 0; s < NS; s++) x.ready[s] = (m_cnt[s] < DEPTH);
        exp_q.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check_eq("cdb_en", 128'(o_cdb_en), 128'(x.en));
            check_eq("cdb_fields", 128'({o_cdb_redirect, o_cdb_tag, o_cdb_data, o_cdb_addr}), 128'(x.e));
            check_eq("fu_ready", 128'(o_fu_ready), 128'(x.ready));
        end
        if (o_cdb_en === 1'b1) log_q.push_back(o_cdb_tag);
        if (o_fu_ready[1] === 1'b0) saw_ready1_low = 1'b1;
    endtask

    task automatic tick();
        drive_inputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_out();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    logic [TAG_W-1:0] sub_q[$];

    initial begin
        n_cmp = 0; n_err = 0; m_rr = 0; m_en = 1'b0; m_last = '0;
        saw_ready1_low = 1'b0;
        rst = 1'b0; i_flush = 1'b0;
        for (int s = 0; s < NS; s++) begin
            s_head[s] = 0; s_tail[s] = 0; m_cnt[s] = 0;
        end

        // Reset then idle
        do_reset(2);
        log_q.delete();
        repeat (10) tick();
        check_eq("idle_bcasts", 128'(log_q.size()), 128'(0));
        check_eq("idle_ready", 128'(o_fu_ready), 128'(4'hF));

        // Single result from source 2
        log_q.delete();
        add_stim(2, 1'b0, 6'd5, 32'hDEADBEEF, 32'h0);
        repeat (6) tick();
        check_eq("single_count", 128'(log_q.size()), 128'(1));
        if (log_q.size() > 0) check_eq("single_tag", 128'(log_q[0]), 128'(6'd5));

        // Fairness with all sources streaming
        do_reset(1);
        log_q.delete();
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < 8; i++)
                add_stim(s, 1'b0, TAG_W'(16 + s), DATA_W'((s << 8) | i), ADDR_W'(i));
        repeat (40) tick();
        check_eq("fair_count", 128'(log_q.size()), 128'(32));
        for (int i = 0; i < 32 && i < log_q.size(); i++)
            check_eq("fair_order", 128'(log_q[i]), 128'(16 + (i % 4)));

        // Backpressure on source 1
        do_reset(1);
        log_q.delete();
        saw_ready1_low = 1'b0;
        for (int i = 0; i < 8; i++) add_stim(0, 1'b0, TAG_W'(32 + i), DATA_W'(i), ADDR_W'(0));
        for (int i = 0; i < 4; i++) add_stim(1, 1'b0, TAG_W'(40 + i), DATA_W'(100 + i), ADDR_W'(0));
        for (int i = 0; i < 4; i++) add_stim(2, 1'b0, TAG_W'(48 + i), DATA_W'(200 + i), ADDR_W'(0));
        repeat (30) tick();
        check_eq("bp_ready1_low", 128'(saw_ready1_low), 128'(1));
        sub_q.delete();
        foreach (log_q[i]) if (log_q[i] >= 6'd40 && log_q[i] <= 6'd43) sub_q.push_back(log_q[i]);
        check_eq("bp_src1_count", 128'(sub_q.size()), 128'(4));
        for (int i = 0; i < sub_q.size(); i++)
            check_eq("bp_src1_order", 128'(sub_q[i]), 128'(40 + i));
        check_eq("bp_total", 128'(log_q.size()), 128'(16));

        // Flush with buffered entries and a simultaneous push from source 3
        do_reset(1);
        log_q.delete();
        add_stim(0, 1'b0, 6'h01, 32'h1, 32'h0);
        add_stim(0, 1'b0, 6'h02, 32'h2, 32'h0);
        add_stim(1, 1'b0, 6'h03, 32'h3, 32'h0);
        add_stim(2, 1'b0, 6'h04, 32'h4, 32'h0);
        tick();
        i_flush = 1'b1;
        add_stim(3, 1'b0, 6'h3F, 32'hBAD, 32'h0);
        tick();
        i_flush = 1'b0;
        check_eq("flush_en", 128'(o_cdb_en), 128'(0));
        repeat (8) tick();
        check_eq("flush_no_bcast", 128'(log_q.size()), 128'(0));

        // Reset in the middle of operation
        add_stim(0, 1'b0, 6'h05, 32'h5, 32'h0);
        add_stim(1, 1'b0, 6'h06, 32'h6, 32'h0);
        tick();
        do_reset(1);
        check_eq("midrst_en", 128'(o_cdb_en), 128'(0));
        repeat (5) tick();
        check_eq("midrst_no_bcast", 128'(log_q.size()), 128'(0));

        // Redirect versus normal head arriving together
        do_reset(1);
        log_q.delete();
        add_stim(0, 1'b0, 6'd1, 32'h11, 32'h0);
        add_stim(3, 1'b1, 6'd2, 32'h22, 32'h400);
        repeat (5) tick();
        check_eq("redir_count", 128'(log_q.size()), 128'(2));
        if (log_q.size() == 2) begin
`ifdef CDB_REDIRECT_PRIORITY_EN
            check_eq("redir_first", 128'(log_q[0]), 128'(6'd2));
            check_eq("redir_second", 128'(log_q[1]), 128'(6'd1));
`else
            check_eq("redir_first", 128'(log_q[0]), 128'(6'd1));
            check_eq("redir_second", 128'(log_q[1]), 128'(6'd2));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
